// File: rtl/mul_add_pipe_pkg.sv
// mul_add_pipe_pkg: op encoding and pipeline depth shared by mul_add_pipe and its bench
package mul_add_pipe_pkg;
    typedef enum logic [1:0] {OP_MADD = 2'd0, OP_MSUB = 2'd1, OP_RSUB = 2'd2, OP_MUL = 2'd3} op_e;
    localparam int MUL_ADD_PIPE_LATENCY = 3;
endpackage

// File: rtl/mul_add_pipe_stage.sv
// mul_add_pipe_stage: valid/ready register slice, payload loads only on an accepted transfer
module mul_add_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clk) begin
        if (rst) out_valid <= 1'b0;
        else if (in_ready) out_valid <= in_valid;
        if (!rst && in_valid && in_ready) out_data <= in_data;
    end
endmodule

// File: rtl/mul_add_pipe.sv
// mul_add_pipe: 3-stage flow-controlled x*y(+/-)z mod 2^WIDTH; MUL_ADD_PIPE_OVF_EN adds out_ovf
module mul_add_pipe
    import mul_add_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
`ifdef MUL_ADD_PIPE_OVF_EN
    output logic             out_ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);
`ifdef MUL_ADD_PIPE_OVF_EN
    localparam int OV = 1;
    localparam int SW = WIDTH + 1;
`else
    localparam int OV = 0;
    localparam int SW = WIDTH;
`endif
    localparam int P0 = 3 * WIDTH + 2 + TAG_W;
    localparam int P1 = 2 * WIDTH + 2 + TAG_W + OV;
    localparam int P2 = WIDTH + TAG_W + OV;
    logic [P0-1:0] d0, q0;
    logic [P1-1:0] d1, q1;
    logic [P2-1:0] d2, q2;
    logic v0, v1, r1, r2;
    logic [WIDTH-1:0] x0, y0, z0, p1, z1;
    logic [1:0] op0, op1;
    logic [TAG_W-1:0] t0, t1;
    logic [SW-1:0] sum;
    assign d0 = {in_x, in_y, in_z, in_op, in_tag};
    assign {x0, y0, z0, op0, t0} = q0;
`ifdef MUL_ADD_PIPE_OVF_EN
    logic [2*WIDTH-1:0] full;
    logic pov1;
    assign full = {{WIDTH{1'b0}}, x0} * {{WIDTH{1'b0}}, y0};
    assign d1 = {full[WIDTH-1:0], z0, op0, t0, |full[2*WIDTH-1:WIDTH]};
    assign {p1, z1, op1, t1, pov1} = q1;
`else
    logic [WIDTH-1:0] prod;
    assign prod = x0 * y0;
    assign d1 = {prod, z0, op0, t0};
    assign {p1, z1, op1, t1} = q1;
`endif
    // with the extra top bit, sum[WIDTH] is the carry-out or borrow of the selected op
    always_comb sum = op1 == OP_MADD ? SW'(p1) + SW'(z1) :
                      op1 == OP_MSUB ? SW'(p1) - SW'(z1) :
                      op1 == OP_RSUB ? SW'(z1) - SW'(p1) : SW'(p1);
`ifdef MUL_ADD_PIPE_OVF_EN
    assign d2 = {sum[WIDTH-1:0], t1, sum[WIDTH] | pov1};
    assign {out_result, out_tag, out_ovf} = q2;
`else
    assign d2 = {sum, t1};
    assign {out_result, out_tag} = q2;
`endif
    mul_add_pipe_stage #(.W(P0)) s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(d0),
        .out_valid(v0), .out_ready(r1), .out_data(q0)
    );
    mul_add_pipe_stage #(.W(P1)) s1 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r1), .in_data(d1),
        .out_valid(v1), .out_ready(r2), .out_data(q1)
    );
    mul_add_pipe_stage #(.W(P2)) s2 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r2), .in_data(d2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(q2)
    );
endmodule
